// File: rtl/branch_resolver_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver_if
//  Description : Fetch/decode/predictor-update signal bundle for branch_resolver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolver_if;
    logic        pushf;
    logic [31:0] pcf;
    logic        predtakenf;
    logic [31:0] predtargetf;
    logic        resolved;
    logic        actualtaken;
    logic [31:0] actualtarget;
    logic        upd_ready;

    logic        redirect;
    logic [31:0] redirectpc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        full;
    logic        empty;
    logic        stallres;
    logic        orphan;
    logic [15:0] brcount;
    logic [15:0] mispcount;

    modport master (
        output pushf, pcf, predtakenf, predtargetf,
        output resolved, actualtaken, actualtarget, upd_ready,
        input  redirect, redirectpc, upd_valid, upd_pc, upd_taken, upd_target,
        input  full, empty, stallres, orphan, brcount, mispcount
    );

    modport slave (
        input  pushf, pcf, predtakenf, predtargetf,
        input  resolved, actualtaken, actualtarget, upd_ready,
        output redirect, redirectpc, upd_valid, upd_pc, upd_taken, upd_target,
        output full, empty, stallres, orphan, brcount, mispcount
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : Tracks in-flight predicted branches, detects mispredicts at
//                decode, issues fetch redirects and queues predictor updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver (
    input  wire                clk,
    input  wire                reset,
    branch_resolver_if.slave   br
);
    localparam logic [2:0]  c_FIFO_FULL = 3'd4;
    localparam logic [1:0]  c_UQ_FULL   = 2'd2;
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    // In-flight prediction FIFO
    logic [31:0] r_fifo_pc  [0:3];
    logic [31:0] r_fifo_tgt [0:3];
    logic [3:0]  r_fifo_pt;
    logic [1:0]  r_rptr;
    logic [1:0]  r_wptr;
    logic [2:0]  r_count;

    // Predictor update queue
    logic [31:0] r_uq_pc  [0:1];
    logic [31:0] r_uq_tgt [0:1];
    logic [1:0]  r_uq_taken;
    logic        r_uq_rptr;
    logic        r_uq_wptr;
    logic [1:0]  r_uq_count;

    logic        r_redirect;
    logic [31:0] r_redirectpc;
    logic        r_orphan;
    logic [15:0] r_brcount;
    logic [15:0] r_mispcount;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_misp;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_tgt;
    logic        w_head_pt;
    logic        w_uq_full;
    logic        w_deq;
    logic        w_enq;

    assign w_empty    = (r_count == 3'd0);
    assign w_full     = (r_count == c_FIFO_FULL);
    assign w_head_pc  = r_fifo_pc[r_rptr];
    assign w_head_tgt = r_fifo_tgt[r_rptr];
    assign w_head_pt  = r_fifo_pt[r_rptr];

    assign w_pop  = br.resolved && !w_empty;
    assign w_misp = w_pop &&
                    ((w_head_pt != br.actualtaken) ||
                     (w_head_pt && br.actualtaken && (w_head_tgt != br.actualtarget)));
    // A full FIFO can still accept when the head leaves cleanly; a flush discards the push.
    assign w_push = br.pushf && !w_misp && (!w_full || w_pop);

    assign w_uq_full = (r_uq_count == c_UQ_FULL);
    assign w_deq     = (r_uq_count != 2'd0) && br.upd_ready;
    assign w_enq     = w_pop && (!w_uq_full || w_deq);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]  <= br.pcf;
            r_fifo_tgt[r_wptr] <= br.predtargetf;
            r_fifo_pt[r_wptr]  <= br.predtakenf;
        end
        if (w_enq) begin
            r_uq_pc[r_uq_wptr]    <= w_head_pc;
            r_uq_tgt[r_uq_wptr]   <= br.actualtarget;
            r_uq_taken[r_uq_wptr] <= br.actualtaken;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr       <= 2'd0;
            r_wptr       <= 2'd0;
            r_count      <= 3'd0;
            r_uq_rptr    <= 1'b0;
            r_uq_wptr    <= 1'b0;
            r_uq_count   <= 2'd0;
            r_redirect   <= 1'b0;
            r_redirectpc <= 32'd0;
            r_orphan     <= 1'b0;
            r_brcount    <= 16'd0;
            r_mispcount  <= 16'd0;
        end else begin
            if (w_misp) begin
                r_rptr  <= r_wptr;
                r_count <= 3'd0;
            end else begin
                r_rptr  <= r_rptr + {1'b0, w_pop};
                r_wptr  <= r_wptr + {1'b0, w_push};
                r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            end

            r_uq_rptr  <= r_uq_rptr ^ w_deq;
            r_uq_wptr  <= r_uq_wptr ^ w_enq;
            r_uq_count <= r_uq_count + {1'b0, w_enq} - {1'b0, w_deq};

            r_redirect <= w_misp;
            if (w_misp) begin
                r_redirectpc <= br.actualtaken ? br.actualtarget : (w_head_pc + 32'd4);
            end

            if (br.resolved && w_empty) begin
                r_orphan <= 1'b1;
            end
            if (w_pop && (r_brcount != c_CNT_MAX)) begin
                r_brcount <= r_brcount + 16'd1;
            end
            if (w_misp && (r_mispcount != c_CNT_MAX)) begin
                r_mispcount <= r_mispcount + 16'd1;
            end
        end
    end

    assign br.redirect   = r_redirect;
    assign br.redirectpc = r_redirectpc;
    assign br.upd_valid  = (r_uq_count != 2'd0);
    assign br.upd_pc     = r_uq_pc[r_uq_rptr];
    assign br.upd_taken  = r_uq_taken[r_uq_rptr];
    assign br.upd_target = r_uq_tgt[r_uq_rptr];
    assign br.full       = w_full;
    assign br.empty      = w_empty;
    assign br.stallres   = w_uq_full;
    assign br.orphan     = r_orphan;
    assign br.brcount    = r_brcount;
    assign br.mispcount  = r_mispcount;
endmodule
`default_nettype wire
